p_psum_acc: RTL

Multi-beat partial-sum accumulator and output stage, placed directly downstream of the single-cycle dot-product accumulator. It collects BEATS consecutive partial sums for one neuron and adds a bias on the first beat. It saturates, applies an optional ReLU, then holds the result behind a valid/ready handshake for the next layer. The block lets a neuron with more than IN inputs reuse one upstream accumulator over several cycles.

---
 rtl/p_psum_acc_if.sv | 36 +++
 rtl/p_psum_acc.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/p_psum_acc_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : p_psum_acc_if                                      |
// | Description : Beat-in / result-out bundle of the partial-sum     |
// |               accumulator. The slave side is the accumulator;    |
// |               the master side is the upstream/downstream pair.   |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface p_psum_acc_if #(
   parameter int PREC = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [PREC-1:0] in_psum;
   logic                   in_ovf;
   logic                   in_udf;
   logic                   in_rounded;
   logic signed [PREC-1:0] bias;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [PREC-1:0] out;
   logic                   out_ovf;
   logic                   out_udf;
   logic                   out_rounded;

   modport slave (
      input  in_valid, in_psum, in_ovf, in_udf, in_rounded, bias, out_ready,
      output in_ready, out_valid, out, out_ovf, out_udf, out_rounded
   );

   modport master (
      output in_valid, in_psum, in_ovf, in_udf, in_rounded, bias, out_ready,
      input  in_ready, out_valid, out, out_ovf, out_udf, out_rounded
   );
endinterface
`default_nettype wire

// File: rtl/p_psum_acc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : p_psum_acc                                         |
// | Description : Collects BEATS partial sums for one neuron, adds   |
// |               the bias on beat 0, saturates or wraps, applies    |
// |               optional ReLU and holds the result behind a        |
// |               valid/ready handshake with sticky status flags.    |
// |               PREC is the data precision (CONF.prec).            |
// |               Macro P_PSUM_SAT_EN: clamp on overflow instead of  |
// |               wrapping modulo 2^PREC.                            |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module p_psum_acc #(
   parameter int PREC  = 8,
   parameter int BEATS = 4,
   parameter int ACT   = 1
) (
   input  logic          clk,
   input  logic          reset,
   p_psum_acc_if.slave   psum_io
);

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [0:0] ST_ACC = 1'b0;
   localparam logic [0:0] ST_OUT = 1'b1;

   localparam logic signed [PREC-1:0] C_MAX = {1'b0, {(PREC-1){1'b1}}};
   localparam logic signed [PREC-1:0] C_MIN = {1'b1, {(PREC-1){1'b0}}};

   logic [0:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic signed [PREC-1:0] acc_q, acc_d;
   logic                   ovf_q, ovf_d;
   logic                   udf_q, udf_d;
   logic                   rnd_q, rnd_d;
   logic signed [PREC-1:0] out_q, out_d;
   logic                   out_ovf_q, out_ovf_d;
   logic                   out_udf_q, out_udf_d;
   logic                   out_rnd_q, out_rnd_d;

   logic                   beat_hs;
   logic                   first_beat;
   logic                   last_beat;
   logic signed [PREC-1:0] addend;
   logic signed [PREC:0]   sum_wide;
   logic                   add_ovf;
   logic signed [PREC-1:0] sum_sat;
   logic signed [PREC-1:0] sum_act;
   logic                   nxt_ovf;
   logic                   nxt_udf;
   logic                   nxt_rnd;

   // Datapath: one guarded add per beat plus saturation and activation.
   always_comb begin
      beat_hs    = psum_io.in_valid && (state_q == ST_ACC);
      first_beat = (cnt_q == '0);
      last_beat  = (cnt_q == CW'(BEATS - 1));
      addend     = first_beat ? psum_io.bias : acc_q;
      // One guard bit: the two top bits disagree exactly when the
      // PREC-bit result would be out of range, in either direction.
      sum_wide   = {addend[PREC-1], addend} + {psum_io.in_psum[PREC-1], psum_io.in_psum};
      add_ovf    = sum_wide[PREC] ^ sum_wide[PREC-1];
`ifdef P_PSUM_SAT_EN
      if (add_ovf) begin
         sum_sat = sum_wide[PREC] ? C_MIN : C_MAX;
      end else begin
         sum_sat = sum_wide[PREC-1:0];
      end
`else
      sum_sat    = sum_wide[PREC-1:0];
`endif
      if ((ACT == 1) && sum_sat[PREC-1]) begin
         sum_act = '0;
      end else begin
         sum_act = sum_sat;
      end
      // Beat 0 restarts the sticky flags; later beats accumulate into them.
      nxt_ovf = (first_beat ? 1'b0 : ovf_q) | psum_io.in_ovf | add_ovf;
      nxt_udf = (first_beat ? 1'b0 : udf_q) | psum_io.in_udf;
      nxt_rnd = (first_beat ? 1'b0 : rnd_q) | psum_io.in_rounded;
   end

   // Next-state: ACC consumes beats, OUT holds the result until taken.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      rnd_d     = rnd_q;
      out_d     = out_q;
      out_ovf_d = out_ovf_q;
      out_udf_d = out_udf_q;
      out_rnd_d = out_rnd_q;
      case (state_q)
         ST_ACC: begin
            if (beat_hs) begin
               acc_d = sum_sat;
               ovf_d = nxt_ovf;
               udf_d = nxt_udf;
               rnd_d = nxt_rnd;
               if (last_beat) begin
                  cnt_d     = '0;
                  state_d   = ST_OUT;
                  out_d     = sum_act;
                  out_ovf_d = nxt_ovf;
                  out_udf_d = nxt_udf;
                  out_rnd_d = nxt_rnd;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            if (psum_io.out_ready) begin
               state_d = ST_ACC;
            end
         end
      endcase
   end

   // State and output registers; reset discards any partial neuron.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_ACC;
         cnt_q     <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         rnd_q     <= 1'b0;
         out_q     <= '0;
         out_ovf_q <= 1'b0;
         out_udf_q <= 1'b0;
         out_rnd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         rnd_q     <= rnd_d;
         out_q     <= out_d;
         out_ovf_q <= out_ovf_d;
         out_udf_q <= out_udf_d;
         out_rnd_q <= out_rnd_d;
      end
   end

   assign psum_io.in_ready    = (state_q == ST_ACC);
   assign psum_io.out_valid   = (state_q == ST_OUT);
   assign psum_io.out         = out_q;
   assign psum_io.out_ovf     = out_ovf_q;
   assign psum_io.out_udf     = out_udf_q;
   assign psum_io.out_rounded = out_rnd_q;

endmodule
`default_nettype wire
